// File: rtl/xilnx_rst_seq_pkg.sv
// xilnx_rst_seq_pkg: sequencer state encoding and counter width helper
package xilnx_rst_seq_pkg;
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t S_HOLD = 2'd0;
  localparam seq_state_t S_DLY  = 2'd1;
  localparam seq_state_t S_ACK  = 2'd2;
  localparam seq_state_t S_RUN  = 2'd3;
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xilnx_rst_seq_bitsync.sv
// xilnx_rst_seq_bitsync: STAGES-deep 1-bit synchroniser, async active-low reset to 0
module xilnx_rst_seq_bitsync #(
  parameter int STAGES = 3
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  // shift the asynchronous input through the flop chain
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) sync_q <= '0;
    else sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/xilnx_rst_seq.sv
// xilnx_rst_seq: lock-gated staged reset sequencer with software resets; RST_SEQ_ACK_TIMEOUT_EN adds an ack timeout
module xilnx_rst_seq
  import xilnx_rst_seq_pkg::*;
#(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 3,
  parameter int              STAGE_DLY   = 16,
  parameter logic [N_CH-1:0] ACK_MASK    = '0,
  parameter int              SW_RST_MIN  = 8
`ifdef RST_SEQ_ACK_TIMEOUT_EN
  , parameter int            ACK_TO      = 1024
`endif
) (
  input  logic            sys_clk,
  input  logic            sys_rstn,
  input  logic            pll_locked,
  input  logic [N_CH-1:0] sw_rst_req,
  input  logic [N_CH-1:0] ch_ack,
  output logic [N_CH-1:0] ch_rstn,
  output logic            all_done,
  output logic [1:0]      seq_state,
  output logic [N_CH-1:0] ack_timeout
);
  localparam int CNT_W = clog2w(STAGE_DLY);
  localparam int IDX_W = clog2w(N_CH);
  localparam int SW_W  = clog2w(SW_RST_MIN + 1);
  seq_state_t                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [N_CH-1:0]            ch_rstn_q, ch_rstn_d, rel_d, sw_act;
  logic [N_CH-1:0][SW_W-1:0]  sw_q, sw_d;
  logic                       all_done_q, all_done_d, locked_s, adv, ack_exp;
  xilnx_rst_seq_bitsync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i  (sys_clk),
    .rstn_i (sys_rstn),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );
`ifdef RST_SEQ_ACK_TIMEOUT_EN
  localparam int WCNT_W = clog2w(ACK_TO);
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [N_CH-1:0]   to_q, to_d;
  assign ack_exp = (wcnt_q == WCNT_W'(ACK_TO - 1)) & ~ch_ack[idx_q];
  // ack wait counter and sticky timeout flags; lock loss suppresses a same-cycle flag
  always_comb begin
    wcnt_d = (state_q == S_ACK && state_d == S_ACK) ? wcnt_q + 1'b1 : '0;
    to_d   = to_q | ((locked_s && state_q == S_ACK && ack_exp) ? N_CH'(1) << idx_q : '0);
  end
  // timeout state registers
  always_ff @(posedge sys_clk or negedge sys_rstn)
    if (!sys_rstn) begin
      wcnt_q <= '0;
      to_q   <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      to_q   <= to_d;
    end
  assign ack_timeout = to_q;
`else
  assign ack_exp     = 1'b0;
  assign ack_timeout = '0;
`endif
  // sequencing FSM: staged release, optional ack wait, lock loss aborts everything
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rel_d   = (state_q == S_RUN) ? '1 : ch_rstn_q;
    adv     = 1'b0;
    if (state_q == S_HOLD) begin
      state_d = S_DLY;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_DLY) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(STAGE_DLY - 1)) begin
        rel_d[idx_q] = 1'b1;
        cnt_d        = '0;
        state_d      = ACK_MASK[idx_q] ? S_ACK : state_q;
        adv          = !ACK_MASK[idx_q];
      end
    end else if (state_q == S_ACK) adv = ch_ack[idx_q] | ack_exp;
    if (adv) begin
      state_d = (idx_q == IDX_W'(N_CH - 1)) ? S_RUN : S_DLY;
      idx_d   = (idx_q == IDX_W'(N_CH - 1)) ? idx_q : idx_q + 1'b1;
      cnt_d   = '0;
    end
    if (!locked_s) begin
      state_d = S_HOLD;
      idx_d   = '0;
      cnt_d   = '0;
      rel_d   = '0;
    end
  end
  // software reset hold counters, live only while running with lock
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sw_d[i]   = (state_q != S_RUN || !locked_s) ? '0 :
                  sw_rst_req[i] ? SW_W'(SW_RST_MIN) :
                  (sw_q[i] != '0) ? sw_q[i] - 1'b1 : '0;
      sw_act[i] = sw_d[i] != '0;
    end
    ch_rstn_d  = (state_d == S_RUN) ? ~sw_act : rel_d;
    all_done_d = (state_d == S_RUN) && !(|sw_act);
  end
  // sequencer state and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rstn)
    if (!sys_rstn) begin
      state_q    <= S_HOLD;
      idx_q      <= '0;
      cnt_q      <= '0;
      sw_q       <= '0;
      ch_rstn_q  <= '0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      sw_q       <= sw_d;
      ch_rstn_q  <= ch_rstn_d;
      all_done_q <= all_done_d;
    end
  assign ch_rstn   = ch_rstn_q;
  assign all_done  = all_done_q;
  assign seq_state = state_q;
endmodule

// File: tb/tb_xilnx_rst_seq.sv
// tb_xilnx_rst_seq: scoreboard bench for the reset sequencer
module tb_xilnx_rst_seq;
  logic clk = 1'b0, rstn = 1'b1, lock = 1'b0;
  logic [3:0] sw_a = '0, sw_z = '0, ack_a = '0, ack_b = '0, ack_c = '0;
  logic [3:0] ch_a, ch_b, ch_c, to_a, to_b, to_c, pa, pb;
  logic done_a, done_b, done_c;
  logic [1:0] st_a, st_b, st_c;
  int cyc = 0, n_run = 0, n_fail = 0;
  bit mon_en = 1'b0;
  typedef struct { logic [3:0] v; int t; } ev_t;
  ev_t qa[$], qb[$], ea, eb;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  xilnx_rst_seq #(.N_CH(4), .SYNC_STAGES(3), .STAGE_DLY(16), .ACK_MASK(4'b0000), .SW_RST_MIN(8)) u_a (
    .sys_clk(clk), .sys_rstn(rstn), .pll_locked(lock), .sw_rst_req(sw_a), .ch_ack(ack_a),
    .ch_rstn(ch_a), .all_done(done_a), .seq_state(st_a), .ack_timeout(to_a));
  xilnx_rst_seq #(.N_CH(4), .SYNC_STAGES(3), .STAGE_DLY(16), .ACK_MASK(4'b0010), .SW_RST_MIN(8)) u_b (
    .sys_clk(clk), .sys_rstn(rstn), .pll_locked(lock), .sw_rst_req(sw_z), .ch_ack(ack_b),
    .ch_rstn(ch_b), .all_done(done_b), .seq_state(st_b), .ack_timeout(to_b));
  xilnx_rst_seq #(.N_CH(4), .SYNC_STAGES(3), .STAGE_DLY(16), .ACK_MASK(4'b0001), .SW_RST_MIN(8)) u_c (
    .sys_clk(clk), .sys_rstn(rstn), .pll_locked(lock), .sw_rst_req(sw_z), .ch_ack(ack_c),
    .ch_rstn(ch_c), .all_done(done_c), .seq_state(st_c), .ack_timeout(to_c));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push_full_a(input int t);
    qa.push_back('{4'b0001, t + 16});
    qa.push_back('{4'b0011, t + 32});
    qa.push_back('{4'b0111, t + 48});
    qa.push_back('{4'b1111, t + 64});
  endtask
  always @(negedge clk) begin
    if (mon_en && ch_a !== pa) begin
      if (qa.size() == 0) chk("a_spurious", ch_a, pa);
      else begin
        ea = qa.pop_front();
        chk("a_val", ch_a, ea.v);
        chk("a_cyc", cyc, ea.t);
      end
    end
    pa = ch_a;
  end
  always @(negedge clk) begin
    if (mon_en && ch_b !== pb) begin
      if (qb.size() == 0) chk("b_spurious", ch_b, pb);
      else begin
        eb = qb.pop_front();
        chk("b_val", ch_b, eb.v);
        chk("b_cyc", cyc, eb.t);
      end
    end
    pb = ch_b;
  end
  initial begin
    int t, r, p, l, t2, t3, t4;
    #2 rstn = 1'b0;
    wait_cyc(3);
    chk("rst_ch_a", ch_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_st_a", st_a, 0);
    chk("rst_to_a", to_a, 0);
    chk("rst_ch_c", ch_c, 0);
    chk("rst_to_c", to_c, 0);
    rstn = 1'b1;
    mon_en = 1'b1;
    wait_cyc(5);
    lock = 1'b1;
    t = cyc + 4;
    r = t + 32;
    push_full_a(t);
    qb.push_back('{4'b0001, t + 16});
    qb.push_back('{4'b0011, r});
    wait_cyc(t);
    chk("hold_to_dly", st_a, 1);
    wait_cyc(t + 16);
    chk("c_ack_wait", st_c, 2);
    wait_cyc(t + 31);
    chk("b_dly", st_b, 1);
    wait_cyc(t + 63);
    chk("done_early", done_a, 0);
    wait_cyc(t + 64);
    chk("done_a", done_a, 1);
    chk("run_a", st_a, 3);
    wait_cyc(r + 50);
    chk("b_ack_state", st_b, 2);
    chk("b_ack_done", done_b, 0);
    wait_cyc(r + 99);
    ack_b = 4'b0010;
    qb.push_back('{4'b0111, r + 116});
    qb.push_back('{4'b1111, r + 132});
    wait_cyc(r + 132);
    chk("done_b", done_b, 1);
    p = t + 200;
    wait_cyc(p);
    sw_a = 4'b0100;
    qa.push_back('{4'b1011, p + 1});
    qa.push_back('{4'b1111, p + 9});
    wait_cyc(p + 1);
    sw_a = '0;
    chk("sw_done_lo0", done_a, 0);
    wait_cyc(p + 8);
    chk("sw_done_lo7", done_a, 0);
    wait_cyc(p + 9);
    chk("sw_done_back", done_a, 1);
    p = t + 250;
    wait_cyc(p);
    sw_a = 4'b0001;
    qa.push_back('{4'b1110, p + 1});
    qa.push_back('{4'b1111, p + 13});
    wait_cyc(p + 1);
    sw_a = '0;
    wait_cyc(p + 4);
    sw_a = 4'b0001;
    wait_cyc(p + 5);
    sw_a = '0;
    p = t + 300;
    wait_cyc(p);
    sw_a = 4'b0110;
    qa.push_back('{4'b1001, p + 1});
    qa.push_back('{4'b1111, p + 9});
    wait_cyc(p + 1);
    sw_a = '0;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    wait_cyc(t + 1039);
    chk("to_before", to_c, 0);
    chk("to_wait_st", st_c, 2);
    wait_cyc(t + 1040);
    chk("to_set", to_c, 4'b0001);
    chk("to_adv_st", st_c, 1);
    wait_cyc(t + 1100);
    chk("to_seq_ch", ch_c, 4'b1111);
    chk("to_seq_done", done_c, 1);
`else
    wait_cyc(t + 1100);
    chk("c_still_wait", st_c, 2);
    chk("c_ch", ch_c, 4'b0001);
    chk("c_no_to", to_c, 0);
`endif
    chk("a_left1", qa.size(), 0);
    chk("b_left1", qb.size(), 0);
    chk("b_no_to", to_b, 0);
    l = t + 1200;
    wait_cyc(l);
    lock = 1'b0;
    qa.push_back('{4'b0000, l + 4});
    qb.push_back('{4'b0000, l + 4});
    wait_cyc(l + 3);
    chk("loss_pre_st", st_a, 3);
    wait_cyc(l + 4);
    chk("loss_st_a", st_a, 0);
    chk("loss_done_a", done_a, 0);
    chk("loss_ch_c", ch_c, 0);
    chk("loss_st_c", st_c, 0);
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    chk("to_sticky", to_c, 4'b0001);
`endif
    wait_cyc(l + 10);
    sw_a = 4'b1111;
    wait_cyc(l + 11);
    sw_a = '0;
    wait_cyc(l + 20);
    lock = 1'b1;
    t2 = cyc + 4;
    qa.push_back('{4'b0001, t2 + 16});
    qa.push_back('{4'b0011, t2 + 32});
    qa.push_back('{4'b0000, t2 + 44});
    qb.push_back('{4'b0001, t2 + 16});
    qb.push_back('{4'b0011, t2 + 32});
    qb.push_back('{4'b0000, t2 + 44});
    wait_cyc(t2 + 40);
    chk("mid_dly_st", st_a, 1);
    lock = 1'b0;
    wait_cyc(t2 + 44);
    chk("mid_loss_st", st_a, 0);
    wait_cyc(t2 + 60);
    lock = 1'b1;
    t3 = cyc + 4;
    push_full_a(t3);
    qb.push_back('{4'b0001, t3 + 16});
    qb.push_back('{4'b0011, t3 + 32});
    qb.push_back('{4'b0111, t3 + 49});
    qb.push_back('{4'b1111, t3 + 65});
    wait_cyc(t3 + 64);
    chk("replay_done_a", done_a, 1);
    wait_cyc(t3 + 65);
    chk("replay_st_b", st_b, 3);
    wait_cyc(t3 + 80);
    lock = 1'b0;
    qa.push_back('{4'b0000, t3 + 84});
    qb.push_back('{4'b0000, t3 + 84});
    wait_cyc(t3 + 90);
    lock = 1'b1;
    t4 = cyc + 4;
    qa.push_back('{4'b0001, t4 + 16});
    qa.push_back('{4'b0011, t4 + 32});
    qb.push_back('{4'b0001, t4 + 16});
    qb.push_back('{4'b0011, t4 + 32});
    wait_cyc(t4 + 40);
    chk("a_left2", qa.size(), 0);
    chk("b_left2", qb.size(), 0);
    mon_en = 1'b0;
    #3 rstn = 1'b0;
    #1;
    chk("arst_ch_a", ch_a, 0);
    chk("arst_ch_b", ch_b, 0);
    chk("arst_ch_c", ch_c, 0);
    chk("arst_st_a", st_a, 0);
    chk("arst_to_c", to_c, 0);
    wait_cyc(cyc + 3);
    chk("arst_hold_st_b", st_b, 0);
    chk("arst_hold_ch_a", ch_a, 0);
    chk("arst_hold_done", done_a, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
